tea_cbc_ctrl: RTL
=================

TEA_CBC_CTRL -- requirements
Module: tea_cbc_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32, meaning the width of each data half-word.
REQ-002 The block SHALL have parameter CNT_SIZE, default 16, meaning the width of the block counter.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 iValid  input  1  upstream block valid.
REQ-006 oReady  output  1  block accepts upstream data.
REQ-007 iP0, iP1  input  WORD_SIZE each  input block halves.
REQ-008 iMode  input  1  0 = encrypt, 1 = decrypt; sampled at accept.
REQ-009 iLoadIV  input  1  load the chaining register.
REQ-010 iIV0, iIV1  input  WORD_SIZE each  initialisation vector.
REQ-011 oStartCipher, oStartDecipher  output  1 each  start pulses to the cipher and decipher cores.
REQ-012 oCoreV0, oCoreV1  output  WORD_SIZE each  operand driven to the cores.
REQ-013 iCoreC0, iCoreC1  input  WORD_SIZE each  cipher core result.
REQ-014 iCoreP0, iCoreP1  input  WORD_SIZE each  decipher core result.
REQ-015 iDoneCipher, iDoneDecipher  input  1 each  core done strobes.
REQ-016 oValid  output  1  result valid.
REQ-017 iReady  input  1  downstream accepts the result.
REQ-018 oD0, oD1  output  WORD_SIZE each  result block.
REQ-019 oBlockCount  output  CNT_SIZE  number of completed blocks.

Function
REQ-020 The FSM SHALL have four states with these transitions: IDLE -> START on iValid&oReady; START -> WAIT unconditionally; WAIT -> OUT on the done strobe of the selected core; OUT -> IDLE on iReady.
REQ-021 oReady SHALL be 1 only in IDLE with rst low.
REQ-022 On accept, the block SHALL latch iP0/iP1 and iMode.
REQ-023 The selected start output SHALL be high for exactly the one cycle the FSM is in START; the other start output SHALL stay 0.
REQ-024 oCoreV0/V1 SHALL be held stable from START until the WAIT -> OUT transition.
REQ-025 The done strobe of the non-selected core, and any done strobe outside WAIT, SHALL be ignored.
REQ-026 On the done cycle, the block SHALL register the result into oD0/oD1, set oValid=1 from the next cycle, and hold oD0/oD1 stable until iReady.
REQ-027 oBlockCount SHALL increment on OUT&iReady and SHALL wrap from all-ones to 0.
REQ-028 Minimum latency SHALL be accept -> oValid = core latency + 2 cycles.
REQ-029 iLoadIV SHALL be honoured only in IDLE; elsewhere it SHALL be ignored.
REQ-030 When iLoadIV and an accept occur in the same cycle, the accepted block SHALL use the new IV.
REQ-031 All XORs SHALL be bitwise per WORD_SIZE half, with no carries.

Reset
REQ-032 When rst is high, the FSM SHALL go to IDLE from any state, including mid-operation.
REQ-033 During reset, all outputs and the chaining register SHALL be 0; oReady SHALL be 0 while rst is high.
REQ-034 A core done strobe arriving after a mid-operation reset SHALL be ignored (FSM is in IDLE).

Configuration
REQ-035 Macro TEA_CBC_CHAIN_EN defined: CBC mode.
- Encrypt: core operand = P xor chain; result C; chain <= C.
- Decrypt: core operand = C; result = core output xor chain; chain <= C (the input block).
REQ-036 Macro TEA_CBC_CHAIN_EN undefined: ECB mode.
- Core operand = input block; result = core output.
- The chaining register, iLoadIV and iIV0/iIV1 SHALL have no effect.

Verification
REQ-037 Bench uses real cipher/decipher cores with key 0 and macro undefined: encrypt 0x00000000/0x00000000 -> oD0/oD1 = 0x41ea3a0a/0x94baa940, oBlockCount = 1.
REQ-038 Macro defined, IV 0x11111111/0x22222222, encrypt then decrypt the resulting ciphertext with the IV reloaded -> original plaintext returned.
REQ-039 iReady held low 10 cycles in OUT -> oValid stays 1, oD0/oD1 stable, oReady stays 0, no second start pulse.
REQ-040 Assert rst for one cycle during WAIT, then inject a late iDoneCipher -> oValid stays 0, FSM in IDLE, oReady = 1 after rst deasserts.
REQ-041 Stub core with 1-cycle done -> accept-to-oValid = 3 cycles; after 65536 blocks oBlockCount = 0 (wrap).
REQ-042 iLoadIV in the same cycle as accept (macro defined) -> core operand = P xor new IV; iLoadIV asserted in WAIT -> chain unchanged.

Source files
------------

// File: rtl/tea_cbc_ctrl.sv
// Block-level controller that sequences one TEA cipher/decipher core operation per accepted block.
// Optional chaining: define TEA_CBC_CHAIN_EN for CBC mode; leave it undefined for ECB mode.
module tea_cbc_ctrl #(
   parameter int WORD_SIZE = 32,
   parameter int CNT_SIZE  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iValid,
   output logic                 oReady,
   input  logic [WORD_SIZE-1:0] iP0,
   input  logic [WORD_SIZE-1:0] iP1,
   input  logic                 iMode,
   input  logic                 iLoadIV,
   input  logic [WORD_SIZE-1:0] iIV0,
   input  logic [WORD_SIZE-1:0] iIV1,
   output logic                 oStartCipher,
   output logic                 oStartDecipher,
   output logic [WORD_SIZE-1:0] oCoreV0,
   output logic [WORD_SIZE-1:0] oCoreV1,
   input  logic [WORD_SIZE-1:0] iCoreC0,
   input  logic [WORD_SIZE-1:0] iCoreC1,
   input  logic [WORD_SIZE-1:0] iCoreP0,
   input  logic [WORD_SIZE-1:0] iCoreP1,
   input  logic                 iDoneCipher,
   input  logic                 iDoneDecipher,
   output logic                 oValid,
   input  logic                 iReady,
   output logic [WORD_SIZE-1:0] oD0,
   output logic [WORD_SIZE-1:0] oD1,
   output logic [CNT_SIZE-1:0]  oBlockCount
);

   typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

   state_t                state_reg, state_next;
   logic [WORD_SIZE-1:0]  v0_reg, v1_reg;
   logic [WORD_SIZE-1:0]  d0_reg, d1_reg;
   logic                  mode_reg;
   logic [CNT_SIZE-1:0]   count_reg;

   logic                  accept;
   logic                  done_sel;
   logic [WORD_SIZE-1:0]  op0, op1;
   logic [WORD_SIZE-1:0]  res0, res1;

   assign accept   = (state_reg == IDLE) && iValid && !rst;
   // Only the core picked for this block may finish it, and only while we wait for it.
   assign done_sel = (state_reg == WAIT) && (mode_reg ? iDoneDecipher : iDoneCipher);

`ifdef TEA_CBC_CHAIN_EN
   logic [WORD_SIZE-1:0]  chain0_reg, chain1_reg;
   logic [WORD_SIZE-1:0]  chain0_eff, chain1_eff;
   logic                  iv_load;

   assign iv_load    = (state_reg == IDLE) && iLoadIV;
   // An IV loaded in the accept cycle must already apply to the block being accepted.
   assign chain0_eff = iv_load ? iIV0 : chain0_reg;
   assign chain1_eff = iv_load ? iIV1 : chain1_reg;
   assign op0        = iMode ? iP0 : (iP0 ^ chain0_eff);
   assign op1        = iMode ? iP1 : (iP1 ^ chain1_eff);
   assign res0       = mode_reg ? (iCoreP0 ^ chain0_reg) : iCoreC0;
   assign res1       = mode_reg ? (iCoreP1 ^ chain1_reg) : iCoreC1;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain0_reg <= '0;
         chain1_reg <= '0;
      end else if (iv_load) begin
         chain0_reg <= iIV0;
         chain1_reg <= iIV1;
      end else if (done_sel) begin
         // Next chain value is always the ciphertext: core output or the decrypt input block.
         chain0_reg <= mode_reg ? v0_reg : iCoreC0;
         chain1_reg <= mode_reg ? v1_reg : iCoreC1;
      end
   end
`else
   logic unused_iv;

   assign unused_iv = ^{iLoadIV, iIV0, iIV1};
   assign op0       = iP0;
   assign op1       = iP1;
   assign res0      = mode_reg ? iCoreP0 : iCoreC0;
   assign res1      = mode_reg ? iCoreP1 : iCoreC1;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept)   state_next = START;
         START:                 state_next = WAIT;
         WAIT:    if (done_sel) state_next = OUT;
         OUT:     if (iReady)   state_next = IDLE;
         default:               state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         v0_reg    <= '0;
         v1_reg    <= '0;
         d0_reg    <= '0;
         d1_reg    <= '0;
         mode_reg  <= 1'b0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            v0_reg   <= op0;
            v1_reg   <= op1;
            mode_reg <= iMode;
         end
         if (done_sel) begin
            d0_reg <= res0;
            d1_reg <= res1;
         end
         if ((state_reg == OUT) && iReady)
            count_reg <= count_reg + 1'b1;
      end
   end

   // Outputs are forced low while rst is held, before the registers clear on the edge.
   assign oReady         = (state_reg == IDLE) && !rst;
   assign oValid         = (state_reg == OUT) && !rst;
   assign oStartCipher   = (state_reg == START) && !mode_reg && !rst;
   assign oStartDecipher = (state_reg == START) && mode_reg && !rst;
   assign oCoreV0        = rst ? '0 : v0_reg;
   assign oCoreV1        = rst ? '0 : v1_reg;
   assign oD0            = rst ? '0 : d0_reg;
   assign oD1            = rst ? '0 : d1_reg;
   assign oBlockCount    = rst ? '0 : count_reg;

endmodule
